// File: rtl/multiport_ram_ctrl.sv
// multiport_ram_ctrl: two-channel initiator front end for a 2R/2W RAM.
// Issues reads/writes, tracks read latency and returns data through FIFOs.
module multiport_ram_ctrl_chan #(
  parameter int P_MEM_WIDTH  = 32,
  parameter int P_RD_LATENCY = 1,
  parameter int P_RSP_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rd_issue,
  input  logic                   rd_fwd,
  input  logic [P_MEM_WIDTH-1:0] fwd_data,
  input  logic [P_MEM_WIDTH-1:0] ram_data,
  input  logic                   rsp_ready,
  output logic                   rsp_valid,
  output logic [P_MEM_WIDTH-1:0] rsp_data,
  output logic                   credit_ok
);
  localparam int LP_PTR_WIDTH = $clog2(P_RSP_DEPTH);
  localparam int LP_CNT_WIDTH = LP_PTR_WIDTH + 1;

  logic [P_RD_LATENCY-1:0] pipe_vld;
  logic [P_RD_LATENCY-1:0] pipe_fwd;
  logic [P_MEM_WIDTH-1:0]  pipe_data [P_RD_LATENCY];
  logic [P_MEM_WIDTH-1:0]  fifo_mem [P_RSP_DEPTH];
  logic [LP_PTR_WIDTH-1:0] wr_ptr;
  logic [LP_PTR_WIDTH-1:0] rd_ptr;
  logic [LP_CNT_WIDTH-1:0] fifo_cnt;
  logic [LP_CNT_WIDTH-1:0] credits;
  logic                    push;
  logic                    pop;
  logic [P_MEM_WIDTH-1:0]  push_data;

  assign push      = pipe_vld[P_RD_LATENCY-1];
  assign push_data = pipe_fwd[P_RD_LATENCY-1] ?
                     pipe_data[P_RD_LATENCY-1] : ram_data;
  assign rsp_valid = fifo_cnt != '0;
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : '0;
  // Credits cover in-flight reads too, so a push never finds the FIFO full
  assign credit_ok = credits < LP_CNT_WIDTH'(P_RSP_DEPTH);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
      pipe_fwd <= '0;
      for (int i = 0; i < P_RD_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_vld[0]  <= rd_issue;
      pipe_fwd[0]  <= rd_fwd;
      pipe_data[0] <= fwd_data;
      for (int i = 1; i < P_RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_fwd[i]  <= pipe_fwd[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      credits  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + LP_CNT_WIDTH'(push) - LP_CNT_WIDTH'(pop);
      credits  <= credits + LP_CNT_WIDTH'(rd_issue) - LP_CNT_WIDTH'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end
endmodule

module multiport_ram_ctrl #(
  parameter int P_MEM_DEPTH     = 2048,
  parameter int P_MEM_WIDTH     = 32,
  parameter int P_RD_LATENCY    = 1,
  parameter int P_RSP_DEPTH     = 4,
  localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      reqa_valid_i,
  output logic                      reqa_ready_o,
  input  logic                      reqa_we_i,
  input  logic [LP_INDEX_WIDTH-1:0] reqa_addr_i,
  input  logic [P_MEM_WIDTH-1:0]    reqa_data_i,
  input  logic                      reqb_valid_i,
  output logic                      reqb_ready_o,
  input  logic                      reqb_we_i,
  input  logic [LP_INDEX_WIDTH-1:0] reqb_addr_i,
  input  logic [P_MEM_WIDTH-1:0]    reqb_data_i,
  output logic                      rspa_valid_o,
  input  logic                      rspa_ready_i,
  output logic [P_MEM_WIDTH-1:0]    rspa_data_o,
  output logic                      rspb_valid_o,
  input  logic                      rspb_ready_i,
  output logic [P_MEM_WIDTH-1:0]    rspb_data_o,
  output logic [LP_INDEX_WIDTH-1:0] rda_addr_o,
  output logic [LP_INDEX_WIDTH-1:0] rdb_addr_o,
  input  logic [P_MEM_WIDTH-1:0]    rda_data_i,
  input  logic [P_MEM_WIDTH-1:0]    rdb_data_i,
  output logic [LP_INDEX_WIDTH-1:0] wra_addr_o,
  output logic [P_MEM_WIDTH-1:0]    wra_data_o,
  output logic                      wra_valid_o,
  output logic [LP_INDEX_WIDTH-1:0] wrb_addr_o,
  output logic [P_MEM_WIDTH-1:0]    wrb_data_o,
  output logic                      wrb_valid_o
);
  logic same_addr;
  logic ww_hazard;
  logic a_issue;
  logic b_issue;
  logic a_wr;
  logic b_wr;
  logic a_rd;
  logic b_rd;
  logic a_credit_ok;
  logic b_credit_ok;

  assign same_addr = reqa_addr_i == reqb_addr_i;
  assign ww_hazard = reqa_valid_i & reqa_we_i &
                     reqb_valid_i & reqb_we_i & same_addr;

  // B wins a same-address write clash; A retries and lands last
  assign reqb_ready_o = ~rst_i & (reqb_we_i | b_credit_ok);
  assign reqa_ready_o = ~rst_i &
                        (reqa_we_i ? ~ww_hazard : a_credit_ok);

  assign a_issue = reqa_valid_i & reqa_ready_o;
  assign b_issue = reqb_valid_i & reqb_ready_o;
  assign a_wr    = a_issue & reqa_we_i;
  assign b_wr    = b_issue & reqb_we_i;
  assign a_rd    = a_issue & ~reqa_we_i;
  assign b_rd    = b_issue & ~reqb_we_i;

  assign wra_valid_o = a_wr;
  assign wra_addr_o  = a_wr ? reqa_addr_i : '0;
  assign wra_data_o  = a_wr ? reqa_data_i : '0;
  assign wrb_valid_o = b_wr;
  assign wrb_addr_o  = b_wr ? reqb_addr_i : '0;
  assign wrb_data_o  = b_wr ? reqb_data_i : '0;
  assign rda_addr_o  = a_rd ? reqa_addr_i : '0;
  assign rdb_addr_o  = b_rd ? reqb_addr_i : '0;

  multiport_ram_ctrl_chan #(
    .P_MEM_WIDTH  (P_MEM_WIDTH),
    .P_RD_LATENCY (P_RD_LATENCY),
    .P_RSP_DEPTH  (P_RSP_DEPTH)
  ) u_cha (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_issue  (a_rd),
    .rd_fwd    (a_rd & b_wr & same_addr),
    .fwd_data  (reqb_data_i),
    .ram_data  (rda_data_i),
    .rsp_ready (rspa_ready_i),
    .rsp_valid (rspa_valid_o),
    .rsp_data  (rspa_data_o),
    .credit_ok (a_credit_ok)
  );

  multiport_ram_ctrl_chan #(
    .P_MEM_WIDTH  (P_MEM_WIDTH),
    .P_RD_LATENCY (P_RD_LATENCY),
    .P_RSP_DEPTH  (P_RSP_DEPTH)
  ) u_chb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_issue  (b_rd),
    .rd_fwd    (b_rd & a_wr & same_addr),
    .fwd_data  (reqa_data_i),
    .ram_data  (rdb_data_i),
    .rsp_ready (rspb_ready_i),
    .rsp_valid (rspb_valid_o),
    .rsp_data  (rspb_data_o),
    .credit_ok (b_credit_ok)
  );
endmodule
